// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_checker
// Description : Receive-side monitor for a Fibonacci generator stream.
//               Consumes one term per in_valid cycle, predicts the next term
//               internally and reports match / mismatch / end-of-sequence.
//               The checker is always ready; it never back-pressures.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous restart (priority over in_valid)
//   in_valid     in_data / in_overflow valid this cycle
//   in_data      received term (WIDTH bits)
//   in_overflow  received overflow flag
//   match        one-cycle pulse: last consumed term was correct
//   error        sticky mismatch flag
//   err_index    0-based index of the first mismatching term
//   err_data     in_data captured at the first mismatch
//   expected     predicted next term (frozen at the first mismatch)
//   term_count   number of consumed terms, saturating at all-ones
//   done         sticky: overflow term correctly received
//
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_overflow,
    output logic             match,
    output logic             error,
    output logic [CNT_W-1:0] err_index,
    output logic [WIDTH-1:0] err_data,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] term_count,
    output logic             done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_EXP0 = 3'd0,   // waiting for the leading 0
        S_EXP1 = 3'd1,   // waiting for the leading 1
        S_RUN  = 3'd2,   // tracking the recurrence
        S_DONE = 3'd3,   // overflow term seen, sequence complete
        S_ERR  = 3'd4    // first mismatch captured, ignoring input
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_curr;
    logic [WIDTH-1:0] r_expected;
    logic             r_match;
    logic             r_error;
    logic             r_done;
    logic [CNT_W-1:0] r_err_index;
    logic [WIDTH-1:0] r_err_data;
    logic [CNT_W-1:0] r_term_count;

    // ------------------------------------------------------------------------
    // Predictor. The sum is one bit wider than the data so the carry out of
    // the top bit flags the term the generator must mark as overflow.
    // Its low WIDTH bits always equal r_expected while in S_RUN.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic             w_ovf_term;
    logic             w_consume;
    logic             w_term_ok;
    logic [CNT_W-1:0] w_count_next;

    assign w_sum      = {1'b0, r_prev} + {1'b0, r_curr};
    assign w_ovf_term = w_sum[WIDTH];

    // Only the three checking states consume terms; DONE and ERR drop them.
    assign w_consume  = in_valid &&
                        ((r_state == S_EXP0) || (r_state == S_EXP1) ||
                         (r_state == S_RUN));

    // Saturating increment so a long stream never wraps the counter.
    assign w_count_next = (&r_term_count) ? r_term_count
                                          : r_term_count + CNT_W'(1);

    // Per-state acceptance test for the incoming term.
    always_comb begin
        w_term_ok = 1'b0;
        case (r_state)
            S_EXP0:  w_term_ok = (in_data == '0)    && !in_overflow;
            S_EXP1:  w_term_ok = (in_data == c_ONE) && !in_overflow;
            S_RUN: begin
                if (w_ovf_term) begin
                    // Overflow term: only the flag matters, data is don't-care.
                    w_term_ok = in_overflow;
                end else begin
                    w_term_ok = (in_data == w_sum[WIDTH-1:0]) && !in_overflow;
                end
            end
            default: w_term_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EXP0;
            r_prev       <= '0;
            r_curr       <= '0;
            r_expected   <= '0;
            r_match      <= 1'b0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_err_index  <= '0;
            r_err_data   <= '0;
            r_term_count <= '0;
        end else if (clear) begin
            // Restart wins over a simultaneous term, which is dropped.
            r_state      <= S_EXP0;
            r_prev       <= '0;
            r_curr       <= '0;
            r_expected   <= '0;
            r_match      <= 1'b0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_err_index  <= '0;
            r_err_data   <= '0;
            r_term_count <= '0;
        end else begin
            // match is a pulse: low unless a correct term lands this cycle.
            r_match <= 1'b0;

            if (w_consume) begin
                // The mismatching term is counted too.
                r_term_count <= w_count_next;

                if (!w_term_ok) begin
                    // Capture the first failure; expected stays frozen at the
                    // value that was predicted for this term.
                    r_state     <= S_ERR;
                    r_error     <= 1'b1;
                    r_err_index <= r_term_count;
                    r_err_data  <= in_data;
                end else begin
                    r_match <= 1'b1;
                    case (r_state)
                        S_EXP0: begin
                            r_state    <= S_EXP1;
                            r_expected <= c_ONE;
                        end
                        S_EXP1: begin
                            r_state    <= S_RUN;
                            r_prev     <= '0;
                            r_curr     <= c_ONE;
                            r_expected <= c_ONE;
                        end
                        S_RUN: begin
                            if (w_ovf_term) begin
                                // Predictor is left as-is; sequence is over.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_prev     <= r_curr;
                                r_curr     <= r_expected;
                                r_expected <= r_curr + r_expected;
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign match      = r_match;
    assign error      = r_error;
    assign done       = r_done;
    assign err_index  = r_err_index;
    assign err_data   = r_err_data;
    assign expected   = r_expected;
    assign term_count = r_term_count;

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci_checker
// Description : Self-checking bench for fibonacci_checker. A table of directed
//               vectors covers the clean run; hand-written sequences cover
//               mismatches, overflow-flag errors, bubbles, restart and
//               counter saturation (second instance, WIDTH=16, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_overflow;
    logic       match, error, done;
    logic [7:0] err_index, err_data, expected, term_count;

    fibonacci_checker #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_overflow(in_overflow),
        .match      (match),
        .error      (error),
        .err_index  (err_index),
        .err_data   (err_data),
        .expected   (expected),
        .term_count (term_count),
        .done       (done)
    );

    // Saturation instance: 16-bit data gives 26 terms, 4-bit counter.
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_overflow;
    logic        s_match, s_error, s_done;
    logic [3:0]  s_err_index, s_term_count;
    logic [15:0] s_err_data, s_expected;

    fibonacci_checker #(.WIDTH(16), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (s_valid),
        .in_data    (s_data),
        .in_overflow(s_overflow),
        .match      (s_match),
        .error      (s_error),
        .err_index  (s_err_index),
        .err_data   (s_err_data),
        .expected   (s_expected),
        .term_count (s_term_count),
        .done       (s_done)
    );

    int tests = 0;
    int fails = 0;

    // Fibonacci terms at WIDTH=8; index 14 is the overflow term (377 mod 256).
    logic [7:0] fib8 [15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                              8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       m;        // expected match
        logic [7:0] cnt;      // expected term_count
        logic [7:0] exp_val;  // expected 'expected'
        logic       chk_exp;  // compare expected this step
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic o);
        @(negedge clk);
        in_valid = v; in_data = d; in_overflow = o;
        @(posedge clk); #1;
    endtask

    task automatic s_step(input logic v, input logic [15:0] d, input logic o);
        @(negedge clk);
        s_valid = v; s_data = d; s_overflow = o;
        @(posedge clk); #1;
    endtask

    task automatic do_clear(input logic v, input logic [7:0] d);
        @(negedge clk);
        clear = 1'b1; in_valid = v; in_data = d; in_overflow = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
    endtask

    // Feed the first n clean terms with 'gaps' idle cycles after each.
    task automatic feed_terms(input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, fib8[i], (i == 14));
            chk($sformatf("feed_match[%0d]", i), match, 1);
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 8'hAA, 1'b0);
                chk($sformatf("gap_match[%0d.%0d]", i, g), match, 0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_match"},  match,      0);
        chk({tag, "_error"},  error,      0);
        chk({tag, "_done"},   done,       0);
        chk({tag, "_eidx"},   err_index,  0);
        chk({tag, "_edata"},  err_data,   0);
        chk({tag, "_exp"},    expected,   0);
        chk({tag, "_count"},  term_count, 0);
    endtask

    initial begin
        // Clean run vectors: {v, d, o, match, count, expected, chk_exp}
        vecs[0]  = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd1,  8'd1,   1'b1};
        vecs[1]  = '{1'b1, 8'd1,   1'b0, 1'b1, 8'd2,  8'd1,   1'b1};
        vecs[2]  = '{1'b1, 8'd1,   1'b0, 1'b1, 8'd3,  8'd2,   1'b1};
        vecs[3]  = '{1'b1, 8'd2,   1'b0, 1'b1, 8'd4,  8'd3,   1'b1};
        vecs[4]  = '{1'b1, 8'd3,   1'b0, 1'b1, 8'd5,  8'd5,   1'b1};
        vecs[5]  = '{1'b1, 8'd5,   1'b0, 1'b1, 8'd6,  8'd8,   1'b1};
        vecs[6]  = '{1'b1, 8'd8,   1'b0, 1'b1, 8'd7,  8'd13,  1'b1};
        vecs[7]  = '{1'b1, 8'd13,  1'b0, 1'b1, 8'd8,  8'd21,  1'b1};
        vecs[8]  = '{1'b1, 8'd21,  1'b0, 1'b1, 8'd9,  8'd34,  1'b1};
        vecs[9]  = '{1'b1, 8'd34,  1'b0, 1'b1, 8'd10, 8'd55,  1'b1};
        vecs[10] = '{1'b1, 8'd55,  1'b0, 1'b1, 8'd11, 8'd89,  1'b1};
        vecs[11] = '{1'b1, 8'd89,  1'b0, 1'b1, 8'd12, 8'd144, 1'b1};
        vecs[12] = '{1'b1, 8'd144, 1'b0, 1'b1, 8'd13, 8'd233, 1'b1};
        vecs[13] = '{1'b1, 8'd233, 1'b0, 1'b1, 8'd14, 8'd121, 1'b1};
        vecs[14] = '{1'b1, 8'd99,  1'b1, 1'b1, 8'd15, 8'd0,   1'b0};

        rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_data = '0; in_overflow = 1'b0;
        s_valid = 1'b0; s_data = '0; s_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // ---- Clean run, in_valid held high ----
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].o);
            chk($sformatf("clean_match[%0d]", i), match, vecs[i].m);
            chk($sformatf("clean_count[%0d]", i), term_count, vecs[i].cnt);
            chk($sformatf("clean_error[%0d]", i), error, 0);
            if (vecs[i].chk_exp)
                chk($sformatf("clean_exp[%0d]", i), expected, vecs[i].exp_val);
        end
        chk("clean_done", done, 1);
        step(1'b0, 8'd0, 1'b0);
        chk("clean_idle_match", match, 0);
        step(1'b1, 8'd5, 1'b0);             // ignored in S_DONE
        chk("done_ignore_count", term_count, 15);
        chk("done_ignore_error", error, 0);
        chk("done_ignore_match", match, 0);

        // ---- Data mismatch: 0,1,1,2,4 ----
        do_clear(1'b0, 8'd0);
        chk("clear_count", term_count, 0);
        chk("clear_done", done, 0);
        feed_terms(4, 0);
        step(1'b1, 8'd4, 1'b0);
        chk("mm_error", error, 1);
        chk("mm_eidx", err_index, 4);
        chk("mm_edata", err_data, 4);
        chk("mm_exp", expected, 3);
        chk("mm_count", term_count, 5);
        chk("mm_match", match, 0);
        step(1'b1, 8'd5, 1'b0);
        chk("mm_ignore_count", term_count, 5);
        chk("mm_ignore_edata", err_data, 4);

        // ---- Clear in S_ERR with a simultaneous term: term dropped ----
        do_clear(1'b1, 8'd0);
        chk("clrv_count", term_count, 0);
        chk("clrv_error", error, 0);
        chk("clrv_match", match, 0);

        // ---- Bubbles: fresh run with 3 idle cycles between terms ----
        feed_terms(15, 3);
        chk("bub_count", term_count, 15);
        chk("bub_done", done, 1);
        chk("bub_error", error, 0);
        chk("bub_exp", expected, 121);

        // ---- Premature overflow on term 5 ----
        do_clear(1'b0, 8'd0);
        feed_terms(5, 0);
        step(1'b1, 8'd5, 1'b1);
        chk("povf_error", error, 1);
        chk("povf_eidx", err_index, 5);
        chk("povf_edata", err_data, 5);
        chk("povf_count", term_count, 6);

        // ---- Missing overflow on term 14 ----
        do_clear(1'b0, 8'd0);
        feed_terms(14, 0);
        step(1'b1, 8'd121, 1'b0);
        chk("movf_error", error, 1);
        chk("movf_eidx", err_index, 14);
        chk("movf_done", done, 0);
        chk("movf_count", term_count, 15);
        chk("movf_match", match, 0);

        // ---- Asynchronous reset mid-clock after term 6 ----
        do_clear(1'b0, 8'd0);
        feed_terms(7, 0);
        chk("pre_rst_count", term_count, 7);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk); rst_n = 1'b1;
        step(1'b1, 8'd0, 1'b0);
        chk("post_rst_match", match, 1);
        chk("post_rst_count", term_count, 1);
        chk("post_rst_exp", expected, 1);
        step(1'b0, 8'd0, 1'b0);

        // ---- Saturation: 16-bit stream into a 4-bit counter ----
        begin
            int a, b, t;
            a = 0; b = 1;
            for (int i = 0; i < 26; i++) begin
                s_step(1'b1, a[15:0], (a > 65535));
                chk($sformatf("sat_match[%0d]", i), s_match, 1);
                chk($sformatf("sat_count[%0d]", i), s_term_count, (i < 15) ? i + 1 : 15);
                t = a + b; a = b; b = t;
            end
        end
        chk("sat_done", s_done, 1);
        chk("sat_error", s_error, 0);
        for (int i = 0; i < 20; i++) s_step(1'b1, 16'd7, 1'b0);
        chk("sat_after_count", s_term_count, 15);
        chk("sat_after_done", s_done, 1);
        chk("sat_after_error", s_error, 0);
        s_step(1'b0, 16'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
- Receive-side monitor for the 8-bit Fibonacci generator stream. Consumes each term and its overflow flag, predicts the next term internally, and reports match, mismatch and end-of-sequence.
- Sits at the generator's output, on silicon and in benches, as a self-checking sink.
- Always ready; every cycle with in_valid=1 consumes exactly one term.

Parameters:
- WIDTH, 8, data width of in_data and of the internal predictor.
- CNT_W, 8, width of term_count and err_index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: returns to S_EXP0 and clears all status; has priority over in_valid.
- in_valid  input  1  in_data and in_overflow are valid this cycle.
- in_data  input  WIDTH  received term.
- in_overflow  input  1  received overflow flag.
- match  output  1  one-cycle pulse: the last consumed term was correct.
- error  output  1  sticky: a mismatch was detected.
- err_index  output  CNT_W  0-based index of the first mismatching term.
- err_data  output  WIDTH  in_data captured at the first mismatch.
- expected  output  WIDTH  value predicted for the next term; at a mismatch it freezes to the value that was expected.
- term_count  output  CNT_W  number of terms consumed; saturates at all-ones.
- done  output  1  sticky: the overflow term was correctly received.

Behaviour:
- Reset (rst_n=0, asynchronous) or clear:
  - state=S_EXP0; prev=0; curr=0; expected=0.
  - match=0, error=0, done=0.
  - err_index=0, err_data=0, term_count=0.
- All outputs are registered. Each result appears one cycle after the in_valid edge. With in_valid=0, state and outputs hold, and match=0.
- States:
  - S_EXP0: expects in_data=0 and in_overflow=0. Match -> S_EXP1, expected=1.
  - S_EXP1: expects 1 with in_overflow=0. Match -> S_RUN, prev=0, curr=1, expected=1.
  - S_RUN: sum = prev + curr computed at WIDTH+1 bits.
    - If sum[WIDTH]=0: expects in_data=expected and in_overflow=0. On match, prev<=curr, curr<=expected, expected<=curr+expected.
    - If the predicted term overflows (expected carry set): expects in_overflow=1, and in_data is don't-care. On match -> S_DONE and done<=1.
  - S_DONE: in_valid terms are ignored. term_count, match and error are unchanged.
  - S_ERR: entered on any mismatch in S_EXP0, S_EXP1 or S_RUN.
    - Same cycle: error<=1, err_index<=term_count, err_data<=in_data, expected frozen.
    - Stays in S_ERR until clear or reset; further terms are ignored.
- The predictor tracks the overflow carry separately, so expected holds the low WIDTH bits of sum. At WIDTH=8 the overflow term is index 14 (sum 377).
- A mismatch is any of:
  - wrong data on a non-overflow term;
  - in_overflow=1 on a non-overflow term (premature overflow);
  - in_overflow=0 on the overflow term (missing overflow).
- term_count increments on every consumed term in S_EXP0, S_EXP1 and S_RUN, including the mismatching term. It does not increment in S_DONE or S_ERR and saturates rather than wrapping.
- match pulses only on a correct term, including the overflow term.
- Simultaneous clear and in_valid: clear wins and the term is dropped.
- Reset mid-sequence: the next consumed term must be 0.

Test Plan:
- Clean run: 15 terms 0,1,1,2,3,5,8,13,21,34,55,89,144,233 then overflow with in_overflow=1, in_valid held high.
  - Required: match pulses 15 times, term_count=15, done=1, error=0.
- Data mismatch: feed 0,1,1,2,4.
  - Required: error=1, err_index=4, err_data=4, expected=3, term_count=5. A following 5 is ignored and term_count stays 5.
- Overflow flag errors:
  - in_overflow=1 on term 5 (data 5) -> error, err_index=5.
  - Separate run with in_overflow=0 at term 14 -> error, err_index=14, done=0.
- Bubbles: clean sequence with in_valid low for 3 cycles between every term.
  - Required: identical final status to the clean run, and match=0 during gaps.
- Restart: assert rst_n=0 asynchronously mid-clock after term 6.
  - Required: all outputs 0 immediately.
  - Then pulse clear in S_ERR together with in_valid (data 0). Required: term dropped, state S_EXP0, and a fresh clean run ends with done=1.
- Saturation: with CNT_W=4, feed 20 terms after done. Required: term_count stays 15 and does not wrap.
